multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 228 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multicycle datapath controller: Moore FSM sequencing fetch, decode, memory,
// R-type, branch and jump phases, with handshaked memory wait states.
module multicycle_control #(
    parameter int OPCODE_WIDTH = 11,
    parameter int ALUOP_WIDTH  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    mem_ready,
    output logic                    pc_write,
    output logic                    pc_write_cond,
    output logic                    ir_write,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    i_or_d,
    output logic                    reg_write,
    output logic                    mem_to_reg,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [ALUOP_WIDTH-1:0]  alu_op,
    output logic [1:0]              pc_source,
    output logic                    illegal,
    output logic [3:0]              state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
    } state_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [ALUOP_WIDTH-1:0] ALU_ADD   = ALUOP_WIDTH'(2'b00);
    localparam logic [ALUOP_WIDTH-1:0] ALU_CBZ   = ALUOP_WIDTH'(2'b01);
    localparam logic [ALUOP_WIDTH-1:0] ALU_RTYPE = ALUOP_WIDTH'(2'b10);

    function automatic logic is_rtype(input logic [OPCODE_WIDTH-1:0] op);
        return (op[10:0] == OP_ADD) || (op[10:0] == OP_SUB) ||
               (op[10:0] == OP_AND) || (op[10:0] == OP_ORR);
    endfunction

    function automatic logic is_ldur(input logic [OPCODE_WIDTH-1:0] op);
        return op[10:0] == OP_LDUR;
    endfunction

    function automatic logic is_stur(input logic [OPCODE_WIDTH-1:0] op);
        return op[10:0] == OP_STUR;
    endfunction

    function automatic logic is_cbz(input logic [OPCODE_WIDTH-1:0] op);
        return op[10:3] == OP_CBZ;
    endfunction

    function automatic logic is_b(input logic [OPCODE_WIDTH-1:0] op);
        return op[10:5] == OP_B;
    endfunction

    function automatic logic is_illegal(input logic [OPCODE_WIDTH-1:0] op);
        return !(is_rtype(op) || is_ldur(op) || is_stur(op) || is_cbz(op) || is_b(op));
    endfunction

    state_t                   state_r;
    state_t                   next_state_s;
    logic                     pc_write_r;
    logic                     pc_write_cond_r;
    logic                     mem_read_r;
    logic                     mem_write_r;
    logic                     i_or_d_r;
    logic                     reg_write_r;
    logic                     mem_to_reg_r;
    logic                     alu_src_a_r;
    logic [1:0]               alu_src_b_r;
    logic [ALUOP_WIDTH-1:0]   alu_op_r;
    logic [1:0]               pc_source_r;
    logic                     state_ok_s;
    logic                     fetch_done_s;

    // The fetch handshake only completes once the read strobe is actually out,
    // so the first edge after reset merely arms FETCH.
    assign state_ok_s   = (state_r <= S_JUMP);
    assign fetch_done_s = (state_r == S_FETCH) && mem_read_r && mem_ready;

    // Next-state selection.
    always_comb begin
        next_state_s = S_FETCH;
        case (state_r)
            S_FETCH: begin
                if (fetch_done_s) next_state_s = S_DECODE;
                else              next_state_s = S_FETCH;
            end
            S_DECODE: begin
                if (is_rtype(opcode))                        next_state_s = S_R_EXEC;
                else if (is_ldur(opcode) || is_stur(opcode)) next_state_s = S_MEM_ADDR;
                else if (is_cbz(opcode))                     next_state_s = S_BRANCH;
                else if (is_b(opcode))                       next_state_s = S_JUMP;
                else                                         next_state_s = S_FETCH;
            end
            S_MEM_ADDR: begin
                if (is_ldur(opcode))      next_state_s = S_MEM_READ;
                else if (is_stur(opcode)) next_state_s = S_MEM_WRITE;
                else                      next_state_s = S_FETCH;
            end
            S_MEM_READ: begin
                if (mem_ready) next_state_s = S_MEM_WB;
                else           next_state_s = S_MEM_READ;
            end
            S_MEM_WRITE: begin
                if (mem_ready) next_state_s = S_FETCH;
                else           next_state_s = S_MEM_WRITE;
            end
            S_MEM_WB: next_state_s = S_FETCH;
            S_R_EXEC: next_state_s = S_R_WB;
            S_R_WB:   next_state_s = S_FETCH;
            S_BRANCH: next_state_s = S_FETCH;
            S_JUMP:   next_state_s = S_FETCH;
            default:  next_state_s = S_FETCH;
        endcase
    end

    // State register plus Moore outputs registered for the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= S_FETCH;
            pc_write_r      <= 1'b0;
            pc_write_cond_r <= 1'b0;
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            i_or_d_r        <= 1'b0;
            reg_write_r     <= 1'b0;
            mem_to_reg_r    <= 1'b0;
            alu_src_a_r     <= 1'b0;
            alu_src_b_r     <= 2'b00;
            alu_op_r        <= ALU_ADD;
            pc_source_r     <= 2'b00;
        end else begin
            state_r         <= next_state_s;
            pc_write_r      <= 1'b0;
            pc_write_cond_r <= 1'b0;
            mem_read_r      <= 1'b0;
            mem_write_r     <= 1'b0;
            i_or_d_r        <= 1'b0;
            reg_write_r     <= 1'b0;
            mem_to_reg_r    <= 1'b0;
            alu_src_a_r     <= 1'b0;
            alu_src_b_r     <= 2'b00;
            alu_op_r        <= ALU_ADD;
            pc_source_r     <= 2'b00;
            case (next_state_s)
                S_FETCH: begin
                    mem_read_r  <= 1'b1;
                    alu_src_b_r <= 2'b01;
                end
                S_DECODE: begin
                    alu_src_b_r <= 2'b11;
                end
                S_MEM_ADDR: begin
                    alu_src_a_r <= 1'b1;
                    alu_src_b_r <= 2'b10;
                end
                S_MEM_READ: begin
                    mem_read_r <= 1'b1;
                    i_or_d_r   <= 1'b1;
                end
                S_MEM_WB: begin
                    reg_write_r  <= 1'b1;
                    mem_to_reg_r <= 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_write_r <= 1'b1;
                    i_or_d_r    <= 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a_r <= 1'b1;
                    alu_op_r    <= ALU_RTYPE;
                end
                S_R_WB: begin
                    reg_write_r <= 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_r     <= 1'b1;
                    alu_op_r        <= ALU_CBZ;
                    pc_write_cond_r <= 1'b1;
                    pc_source_r     <= 2'b01;
                end
                S_JUMP: begin
                    pc_write_r  <= 1'b1;
                    pc_source_r <= 2'b10;
                end
                default: begin
                    mem_read_r <= 1'b0;
                end
            endcase
        end
    end

    // A corrupted state code silences every output until FETCH is re-entered.
    assign pc_write      = state_ok_s & (pc_write_r | fetch_done_s);
    assign ir_write      = fetch_done_s;
    assign pc_write_cond = state_ok_s & pc_write_cond_r;
    assign mem_read      = state_ok_s & mem_read_r;
    assign mem_write     = state_ok_s & mem_write_r;
    assign i_or_d        = state_ok_s & i_or_d_r;
    assign reg_write     = state_ok_s & reg_write_r;
    assign mem_to_reg    = state_ok_s & mem_to_reg_r;
    assign alu_src_a     = state_ok_s & alu_src_a_r;
    assign alu_src_b     = state_ok_s ? alu_src_b_r : 2'b00;
    assign alu_op        = state_ok_s ? alu_op_r : ALU_ADD;
    assign pc_source     = state_ok_s ? pc_source_r : 2'b00;
    assign illegal       = (state_r == S_DECODE) && is_illegal(opcode);
    assign state         = state_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control, driven from per-instruction
// expected state/output traces derived from instruction class and wait counts.
module tb_multicycle_control;

    localparam int OW = 11;
    localparam int AW = 2;
    localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [OW-1:0] opcode;
    logic          mem_ready;
    logic          pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d;
    logic          reg_write, mem_to_reg, alu_src_a, illegal;
    logic [1:0]    alu_src_b, pc_source;
    logic [AW-1:0] alu_op;
    logic [3:0]    state;

    int          n_vec = 0;
    int          n_err = 0;
    int          exp_st[$];
    bit          exp_rdy[$];
    logic [3:0]  obs_st[$];
    logic [15:0] obs_out[$];

    multicycle_control #(.OPCODE_WIDTH(OW), .ALUOP_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] observed();
        return {pc_write, pc_write_cond, ir_write, mem_read, mem_write, i_or_d,
                reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, illegal};
    endfunction

    function automatic int classify(input logic [10:0] op);
        if (op == 11'b10001011000 || op == 11'b11001011000 ||
            op == 11'b10001010000 || op == 11'b10101010000) return C_R;
        if (op == 11'b11111000010) return C_LD;
        if (op == 11'b11111000000) return C_ST;
        if (op[10:3] == 8'b10110100) return C_CBZ;
        if (op[10:5] == 6'b000101) return C_B;
        return C_ILL;
    endfunction

    // Expected control word for a state, straight from the per-state output table.
    function automatic logic [15:0] exp_out(input int st, input bit rdy, input bit ill);
        logic pw = 1'b0, pwc = 1'b0, irw = 1'b0, mr = 1'b0, mw = 1'b0, iod = 1'b0;
        logic rw = 1'b0, m2r = 1'b0, sa = 1'b0, il = 1'b0;
        logic [1:0] sb = 2'b00, aop = 2'b00, ps = 2'b00;
        case (st)
            0: begin mr = 1'b1; sb = 2'b01; if (rdy) begin irw = 1'b1; pw = 1'b1; end end
            1: begin sb = 2'b11; il = ill; end
            2: begin sa = 1'b1; sb = 2'b10; end
            3: begin mr = 1'b1; iod = 1'b1; end
            4: begin rw = 1'b1; m2r = 1'b1; end
            5: begin mw = 1'b1; iod = 1'b1; end
            6: begin sa = 1'b1; aop = 2'b10; end
            7: begin rw = 1'b1; end
            8: begin sa = 1'b1; aop = 2'b01; pwc = 1'b1; ps = 2'b01; end
            9: begin pw = 1'b1; ps = 2'b10; end
            default: pw = 1'b0;
        endcase
        return {pw, pwc, irw, mr, mw, iod, rw, m2r, sa, sb, aop, ps, il};
    endfunction

    function automatic void push(input int st, input bit rdy);
        exp_st.push_back(st);
        exp_rdy.push_back(rdy);
    endfunction

    // Step list for one instruction: wf fetch waits, wm memory waits.
    function automatic void build(input int cls, input int wf, input int wm);
        exp_st.delete();
        exp_rdy.delete();
        for (int i = 0; i < wf; i++) push(0, 1'b0);
        push(0, 1'b1);
        push(1, 1'($urandom));
        case (cls)
            C_R:   begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
            C_LD:  begin
                push(2, 1'($urandom));
                for (int i = 0; i < wm; i++) push(3, 1'b0);
                push(3, 1'b1);
                push(4, 1'($urandom));
            end
            C_ST:  begin
                push(2, 1'($urandom));
                for (int i = 0; i < wm; i++) push(5, 1'b0);
                push(5, 1'b1);
            end
            C_CBZ: push(8, 1'($urandom));
            C_B:   push(9, 1'($urandom));
            default: ;
        endcase
    endfunction

    task automatic apply(input int nsteps, input logic [10:0] op);
        obs_st.delete();
        obs_out.delete();
        for (int i = 0; i < nsteps; i++) begin
            @(negedge clk);
            mem_ready = exp_rdy[i];
            opcode    = (exp_st[i] == 0) ? OW'($urandom) : op;
            #1;
            obs_st.push_back(state);
            obs_out.push_back(observed());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_ready = 1'b1; opcode = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_vec++;
            if (state !== 4'd0 || observed() !== 16'h0) begin
                n_err++;
                $display("FAIL reset_hold: state=%0d outs=%h, want state=0 outs=0000", state, observed());
            end
        end
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; #1;
        n_vec++;
        if (state !== 4'd0 || observed() !== 16'h0) begin
            n_err++;
            $display("FAIL reset_release: state=%0d outs=%h, want state=0 outs=0000", state, observed());
        end
    endtask

    task automatic test_add();
        build(C_R, 0, 0);
        apply(exp_st.size(), 11'b10001011000);
        for (int i = 0; i < obs_st.size(); i++) begin
            n_vec++;
            if (obs_st[i] !== 4'(exp_st[i])) begin
                n_err++; $display("FAIL add_state step %0d: got %0d want %0d", i, obs_st[i], exp_st[i]);
            end
            n_vec++;
            if (obs_out[i] !== exp_out(exp_st[i], exp_rdy[i], 1'b0)) begin
                n_err++; $display("FAIL add_outs step %0d: got %h want %h", i, obs_out[i], exp_out(exp_st[i], exp_rdy[i], 1'b0));
            end
        end
    endtask

    task automatic test_ldur_wait();
        build(C_LD, 0, 2);
        apply(exp_st.size(), 11'b11111000010);
        for (int i = 0; i < obs_st.size(); i++) begin
            n_vec++;
            if (obs_st[i] !== 4'(exp_st[i])) begin
                n_err++; $display("FAIL ldur_state step %0d: got %0d want %0d", i, obs_st[i], exp_st[i]);
            end
            n_vec++;
            if (obs_out[i] !== exp_out(exp_st[i], exp_rdy[i], 1'b0)) begin
                n_err++; $display("FAIL ldur_outs step %0d: got %h want %h", i, obs_out[i], exp_out(exp_st[i], exp_rdy[i], 1'b0));
            end
        end
    endtask

    task automatic test_stur();
        int writes = 0;
        build(C_ST, 0, 0);
        apply(exp_st.size(), 11'b11111000000);
        for (int i = 0; i < obs_st.size(); i++) begin
            writes += int'(obs_out[i][11]);
            n_vec++;
            if (obs_st[i] !== 4'(exp_st[i])) begin
                n_err++; $display("FAIL stur_state step %0d: got %0d want %0d", i, obs_st[i], exp_st[i]);
            end
            n_vec++;
            if (obs_out[i] !== exp_out(exp_st[i], exp_rdy[i], 1'b0)) begin
                n_err++; $display("FAIL stur_outs step %0d: got %h want %h", i, obs_out[i], exp_out(exp_st[i], exp_rdy[i], 1'b0));
            end
        end
        n_vec++;
        if (writes !== 1) begin
            n_err++; $display("FAIL stur_write_count: got %0d want 1", writes);
        end
    endtask

    task automatic test_cbz_b();
        logic [10:0] ops [2];
        int          cls [2];
        ops[0] = 11'b10110100101; cls[0] = C_CBZ;
        ops[1] = 11'b00010100000; cls[1] = C_B;
        for (int k = 0; k < 2; k++) begin
            build(cls[k], 0, 0);
            apply(exp_st.size(), ops[k]);
            for (int i = 0; i < obs_st.size(); i++) begin
                n_vec++;
                if (obs_st[i] !== 4'(exp_st[i])) begin
                    n_err++; $display("FAIL cbz_b_state op %0d step %0d: got %0d want %0d", k, i, obs_st[i], exp_st[i]);
                end
                n_vec++;
                if (obs_out[i] !== exp_out(exp_st[i], exp_rdy[i], 1'b0)) begin
                    n_err++; $display("FAIL cbz_b_outs op %0d step %0d: got %h want %h", k, i, obs_out[i], exp_out(exp_st[i], exp_rdy[i], 1'b0));
                end
            end
        end
    endtask

    task automatic test_illegal();
        build(C_ILL, 1, 0);
        apply(exp_st.size(), 11'b00000000000);
        for (int i = 0; i < obs_st.size(); i++) begin
            n_vec++;
            if (obs_st[i] !== 4'(exp_st[i])) begin
                n_err++; $display("FAIL illegal_state step %0d: got %0d want %0d", i, obs_st[i], exp_st[i]);
            end
            n_vec++;
            if (obs_out[i] !== exp_out(exp_st[i], exp_rdy[i], 1'b1)) begin
                n_err++; $display("FAIL illegal_outs step %0d: got %h want %h", i, obs_out[i], exp_out(exp_st[i], exp_rdy[i], 1'b1));
            end
        end
    endtask

    task automatic test_reset_mid_memread();
        build(C_LD, 0, 4);
        apply(5, 11'b11111000010);
        n_vec++;
        if (obs_st[4] !== 4'd3) begin
            n_err++; $display("FAIL midrst_reach_memread: got state %0d want 3", obs_st[4]);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (state !== 4'd0 || observed() !== 16'h0) begin
            n_err++; $display("FAIL midrst_async: state=%0d outs=%h, want state=0 outs=0000", state, observed());
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); mem_ready = 1'b1; opcode = OW'($urandom); #1;
            n_vec++;
            if (state !== 4'd0 || observed() !== 16'h0) begin
                n_err++; $display("FAIL midrst_hold: state=%0d outs=%h, want state=0 outs=0000", state, observed());
            end
        end
        @(negedge clk); rst_n = 1'b1; mem_ready = 1'b1; #1;
        n_vec++;
        if (state !== 4'd0 || observed() !== 16'h0) begin
            n_err++; $display("FAIL midrst_release: state=%0d outs=%h, want state=0 outs=0000", state, observed());
        end
        build(C_CBZ, 1, 0);
        apply(exp_st.size(), 11'b10110100011);
        for (int i = 0; i < obs_st.size(); i++) begin
            n_vec++;
            if (obs_st[i] !== 4'(exp_st[i]) || obs_out[i] !== exp_out(exp_st[i], exp_rdy[i], 1'b0)) begin
                n_err++; $display("FAIL midrst_restart step %0d: state %0d outs %h, want state %0d outs %h",
                                  i, obs_st[i], obs_out[i], exp_st[i], exp_out(exp_st[i], exp_rdy[i], 1'b0));
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] op;
        int          cls;
        for (int n = 0; n < 40; n++) begin
            cls = int'($urandom_range(0, 5));
            case (cls)
                C_R: begin
                    case ($urandom_range(0, 3))
                        0: op = 11'b10001011000;
                        1: op = 11'b11001011000;
                        2: op = 11'b10001010000;
                        default: op = 11'b10101010000;
                    endcase
                end
                C_LD:  op = 11'b11111000010;
                C_ST:  op = 11'b11111000000;
                C_CBZ: op = {8'b10110100, 3'($urandom)};
                C_B:   op = {6'b000101, 5'($urandom)};
                default: begin
                    op = 11'b00000000000;
                    for (int t = 0; t < 20; t++) begin
                        op = 11'($urandom);
                        if (classify(op) == C_ILL) break;
                    end
                    if (classify(op) != C_ILL) op = 11'b00000000000;
                end
            endcase
            build(cls, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
            apply(exp_st.size(), op);
            for (int i = 0; i < obs_st.size(); i++) begin
                n_vec++;
                if (obs_st[i] !== 4'(exp_st[i])) begin
                    n_err++; $display("FAIL rand_state instr %0d step %0d: got %0d want %0d", n, i, obs_st[i], exp_st[i]);
                end
                n_vec++;
                if (obs_out[i] !== exp_out(exp_st[i], exp_rdy[i], cls == C_ILL)) begin
                    n_err++; $display("FAIL rand_outs instr %0d op %b step %0d: got %h want %h", n, op, i,
                                      obs_out[i], exp_out(exp_st[i], exp_rdy[i], cls == C_ILL));
                end
                n_vec++;
                if (obs_out[i][12] && obs_out[i][11]) begin
                    n_err++; $display("FAIL rand_rw_excl instr %0d step %0d: mem_read=1 mem_write=1, want not both", n, i);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldur_wait();
        test_stur();
        test_cbz_b();
        test_illegal();
        test_reset_mid_memread();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
